// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array result path.
package systolic_pkg;
    localparam int N  = 4;
    localparam int DW = 18;
    localparam int QW = 8;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    function automatic logic [3:0] rm_index(input int i, input int j);
        return 4'(N * i + j);
    endfunction

    // Floor shift followed by a clamp to the signed QW range.
    function automatic logic signed [QW-1:0] sat_shift(input logic signed [DW-1:0] x, input int sh);
        logic signed [DW-1:0] s;
        s = x >>> sh;
        if (s > DW'((1 <<< (QW - 1)) - 1))   return QW'((1 <<< (QW - 1)) - 1);
        else if (s < -DW'(1 <<< (QW - 1)))   return QW'(-(1 <<< (QW - 1)));
        else                                 return s[QW-1:0];
    endfunction
endpackage

// File: rtl/result_sat_quant.sv
// Combinational arithmetic shift and saturate from DW-bit signed to QW-bit signed.
module result_sat_quant #(
    parameter int DW    = 18,
    parameter int QW    = 8,
    parameter int SHIFT = 2
) (
    input  logic signed [DW-1:0] i_data,
    output logic signed [QW-1:0] o_q
);
    localparam logic signed [DW-1:0] QMAX = DW'((1 <<< (QW - 1)) - 1);
    localparam logic signed [DW-1:0] QMIN = DW'(-(1 <<< (QW - 1)));

    logic signed [DW-1:0] w_sh;
    assign w_sh = i_data >>> SHIFT;

    always_comb begin
        o_q = w_sh[QW-1:0];
        if (w_sh > QMAX)      o_q = QMAX[QW-1:0];
        else if (w_sh < QMIN) o_q = QMIN[QW-1:0];
    end
endmodule

// File: rtl/systolic_result_collector.sv
// De-skews the 4x4 systolic array outputs into a buffer and drains it row-major
// over a valid/ready stream with raw and quantized values.
module systolic_result_collector #(
    parameter int DW      = systolic_pkg::DW,
    parameter int QW      = systolic_pkg::QW,
    parameter int LATENCY = 4,
    parameter int SHIFT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] pso0,
    input  logic signed [DW-1:0] pso1,
    input  logic signed [DW-1:0] pso2,
    input  logic signed [DW-1:0] pso3,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic [QW-1:0]        rd_q,
    output logic [3:0]           rd_index,
    output logic                 busy,
    output logic                 done
);
    import systolic_pkg::*;

    localparam logic [4:0] CAP_LAST = 5'(LATENCY + 6);

    state_t               r_state;
    logic [4:0]           r_cnt;
    logic [3:0]           r_idx;
    logic                 r_valid;
    logic                 r_done;
    logic [DW-1:0]        r_data;
    logic [QW-1:0]        r_q;
    logic signed [DW-1:0] r_buf [N*N];

    logic signed [DW-1:0] w_pso [N];
    logic [4:0]           w_k;
    logic                 w_cap;
    logic                 w_hs;
    logic [3:0]           w_rd_addr;
    logic signed [DW-1:0] w_next;
    logic signed [QW-1:0] w_next_q;

    assign w_pso[0] = pso0;
    assign w_pso[1] = pso1;
    assign w_pso[2] = pso2;
    assign w_pso[3] = pso3;

    // The start edge itself is cycle k=0, so capture is also live in IDLE on start.
    assign w_k       = (r_state == IDLE) ? 5'd0 : r_cnt;
    assign w_cap     = (r_state == CAPTURE) || (r_state == IDLE && start);
    assign w_hs      = r_valid && rd_ready;
    assign w_rd_addr = (r_state == DRAIN) ? r_idx + 4'd1 : 4'd0;
    assign w_next    = r_buf[w_rd_addr];

    result_sat_quant #(.DW(DW), .QW(QW), .SHIFT(SHIFT)) u_quant (
        .i_data (w_next),
        .o_q    (w_next_q)
    );

    always_ff @(posedge clk) begin
        if (!rst && w_cap) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (w_k == 5'(LATENCY + i + j)) r_buf[rm_index(i, j)] <= w_pso[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_q     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CAPTURE;
                        r_cnt   <= 5'd1;
                    end
                end
                CAPTURE: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == CAP_LAST) begin
                        r_state <= DRAIN;
                        r_valid <= 1'b1;
                        r_idx   <= 4'd0;
                        r_data  <= w_next;
                        r_q     <= w_next_q;
                    end
                end
                DRAIN: begin
                    if (w_hs) begin
                        if (r_idx == 4'd15) begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + 4'd1;
                            r_data <= w_next;
                            r_q    <= w_next_q;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_valid = r_valid;
    assign rd_data  = r_data;
    assign rd_q     = r_q;
    assign rd_index = r_idx;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
endmodule

// File: tb/tb_systolic_result_collector.sv
// Randomized bench for systolic_result_collector against a matrix-level reference model.
module tb_systolic_result_collector;
    localparam int DW  = 18;
    localparam int QW  = 8;
    localparam int LAT = 4;
    localparam int SH  = 2;

    logic          clk = 1'b0;
    logic          rst, start, rd_ready;
    logic [DW-1:0] pso [4];
    logic          rd_valid, busy, done;
    logic [DW-1:0] rd_data;
    logic [QW-1:0] rd_q;
    logic [3:0]    rd_index;

    int n_chk = 0;
    int n_err = 0;
    int C [16];

    always #5 clk = ~clk;

    systolic_result_collector #(.DW(DW), .QW(QW), .LATENCY(LAT), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pso0(pso[0]), .pso1(pso[1]), .pso2(pso[2]), .pso3(pso[3]),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_q(rd_q),
        .rd_index(rd_index), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // floor(v / 2^SH) clamped to the signed 8-bit range
    function automatic int qref(input int v);
        int d, s;
        d = 1 << SH;
        s = (v >= 0) ? v / d : -((-v + d - 1) / d);
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 600)) - 300;
            1:       return int'($urandom_range(0, 1200)) - 600;
            2:       return ($urandom_range(0, 1) == 1) ? 131071 : -131072;
            default: return int'($signed(DW'($urandom)));
        endcase
    endfunction

    // Column j carries C[i][j] at cycle LAT+i+j; any other cycle carries junk.
    task automatic set_pso(input int k);
        for (int j = 0; j < 4; j++) begin
            int i;
            i = k - LAT - j;
            pso[j] = (i >= 0 && i < 4) ? DW'(C[4*i+j]) : DW'($urandom);
        end
    endtask

    task automatic check_word(input int n);
        chk("rd_valid",  int'(rd_valid), 1);
        chk("rd_index",  int'(rd_index), n);
        chk("rd_data",   int'($signed(rd_data)), C[n]);
        chk("rd_q",      int'($signed(rd_q)), qref(C[n]));
        chk("busy_drn",  int'(busy), 1);
        chk("done_drn",  int'(done), 0);
    endtask

    // mode: 0 ready always, 1 pattern 1,0,0, 2 random
    task automatic run_job(input int mode, input bit chain_in, input bit chain_out,
                           input bit noise, input int abort_at);
        int k, n, p;
        if (!chain_in) @(negedge clk);
        start = 1'b1;
        set_pso(0);
        for (k = 1; k <= LAT + 6; k++) begin
            @(negedge clk);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            set_pso(k);
            chk("busy_cap",  int'(busy), 1);
            chk("valid_cap", int'(rd_valid), 0);
        end
        n = 0;
        p = 0;
        k = LAT + 7;
        while (n < 16 && k < LAT + 7 + 200) begin
            @(negedge clk);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            set_pso(k);
            check_word(n);
            if (n == abort_at) begin
                start = 1'b0;
                rst   = 1'b1;
                @(negedge clk);
                chk("abort_valid", int'(rd_valid), 0);
                chk("abort_busy",  int'(busy), 0);
                chk("abort_done",  int'(done), 0);
                rst = 1'b0;
                @(negedge clk);
                chk("abort_done2", int'(done), 0);
                chk("abort_busy2", int'(busy), 0);
                return;
            end
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (p % 3 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            p++;
            if (rd_ready) n++;
            k++;
        end
        if (n < 16) chk("drain_timeout", n, 16);
        @(negedge clk);
        chk("done_pulse", int'(done), 1);
        chk("done_valid", int'(rd_valid), 0);
        chk("done_busy",  int'(busy), 0);
        if (mode == 0) chk("done_cycle", k, LAT + 23);
        rd_ready = 1'($urandom_range(0, 1));
        start    = chain_out;
        set_pso(99);
        if (chain_out) return;
        @(negedge clk);
        chk("done_clear", int'(done), 0);
        chk("idle_busy",  int'(busy), 0);
    endtask

    task automatic fill_random();
        for (int e = 0; e < 16; e++) C[e] = rnd_val();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rd_ready = 1'b0;
        for (int j = 0; j < 4; j++) pso[j] = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_data",  int'(rd_data), 0);
        chk("rst_q",     int'(rd_q), 0);
        chk("rst_index", int'(rd_index), 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) C[4*i+j] = 100 * i + j;
        run_job(0, 1'b0, 1'b0, 1'b0, -1);

        fill_random();
        C[0] = -1;   C[1] = 6;     C[2] = -15; C[3] = 28;
        C[4] = 1000; C[5] = -1000; C[6] = -1;  C[7] = 131071; C[8] = -131072;
        run_job(0, 1'b0, 1'b0, 1'b0, -1);

        fill_random();
        run_job(1, 1'b0, 1'b1, 1'b1, -1);
        fill_random();
        run_job(2, 1'b1, 1'b0, 1'b1, -1);

        fill_random();
        run_job(0, 1'b0, 1'b0, 1'b0, 5);
        fill_random();
        run_job(0, 1'b0, 1'b0, 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_job(r % 3, 1'b0, 1'b0, 1'(r % 2), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
